// File: rtl/opb_register_simulink2ppc_fifo.sv
// rtl/opb_register_simulink2ppc_fifo.sv - OPB slave draining a user-fed FIFO to the PowerPC (optional PEEK via OPB_S2P_PEEK_EN)
module opb_register_simulink2ppc_fifo #(
    parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_FIFO_AW    = 4,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    input  logic [31:0] user_data_in,
    input  logic        user_valid,
    output logic        user_full
);

    localparam int                 DEPTH     = 1 << C_FIFO_AW;
    localparam logic [C_FIFO_AW:0] DEPTH_CNT = (C_FIFO_AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACK  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_PEEK   = 2'd3;

    logic [1:0]  state;
    logic [1:0]  reg_q;
    logic        rnw_q;
    logic [1:0]  ctrl_q;

    logic [31:0] mem [0:DEPTH-1];
    logic [C_FIFO_AW-1:0] wr_ptr;
    logic [C_FIFO_AW-1:0] rd_ptr;
    logic [C_FIFO_AW:0]   count;
    logic [C_FIFO_AW:0]   count_next;
    logic        ovf_q;
    logic        unf_q;
    logic        full_q;

    logic [31:0] abus;
    logic [31:0] dbus;
    logic [31:0] addr_diff;
    logic        hit;
    logic        acc, rd_acc, wr_acc;
    logic        empty, full_cnt;
    logic        pop_req, pop, push, ovf_evt, unf_evt;
    logic        clr_ovf, clr_unf;
    logic [31:0] head;
    logic [31:0] rd_word;
    logic        unused_inputs;

    // Bus bit 0 is the MSB, so a straight assignment keeps MSB-to-MSB.
    assign abus      = OPB_ABus;
    assign dbus      = OPB_DBus;
    assign addr_diff = abus - C_BASEADDR;
    assign hit       = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

    assign unused_inputs = &{1'b0, OPB_BE, OPB_seqAddr, dbus[31:4], dbus[1:0],
                             addr_diff[31:4], addr_diff[1:0]};

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state  <= S_IDLE;
            reg_q  <= 2'd0;
            rnw_q  <= 1'b0;
            ctrl_q <= 2'd0;
        end else begin
            case (state)
                S_IDLE: if (hit) begin
                    state  <= S_ACK;
                    reg_q  <= addr_diff[3:2];
                    rnw_q  <= OPB_RNW;
                    ctrl_q <= dbus[3:2];
                end
                S_ACK:   state <= S_WAIT;
                S_WAIT:  if (!OPB_select) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign acc    = (state == S_ACK);
    assign rd_acc = acc && rnw_q;
    assign wr_acc = acc && !rnw_q;

    assign empty    = (count == '0);
    assign full_cnt = (count == DEPTH_CNT);
    assign head     = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop_req = rd_acc && (reg_q == REG_DATA);
    assign pop     = pop_req && !empty;
    assign unf_evt = pop_req && empty;
    assign push    = user_valid && (!full_cnt || pop);
    assign ovf_evt = user_valid && !push;
    assign clr_ovf = wr_acc && (reg_q == REG_CTRL) && ctrl_q[0];
    assign clr_unf = wr_acc && (reg_q == REG_CTRL) && ctrl_q[1];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (push) mem[wr_ptr] <= user_data_in;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            full_q <= (count_next == DEPTH_CNT);
            // A new event in the same cycle as a clear keeps the flag set.
            if (ovf_evt)      ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
            if (unf_evt)      unf_q <= 1'b1;
            else if (clr_unf) unf_q <= 1'b0;
        end
    end

    always_comb begin
        rd_word = 32'h0;
        case (reg_q)
            REG_DATA:   rd_word = empty ? 32'h0 : head;
            REG_STATUS: rd_word = {16'h0, 8'(count), 4'h0, unf_q, ovf_q, full_cnt, empty};
`ifdef OPB_S2P_PEEK_EN
            REG_PEEK:   rd_word = empty ? 32'h0 : head;
`endif
            default:    rd_word = 32'h0;
        endcase
    end

    assign Sl_DBus    = rd_acc ? rd_word : 32'h0;
    assign Sl_xferAck = acc;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_full  = full_q;

endmodule

// File: tb/tb_opb_register_simulink2ppc_fifo.sv
// tb/tb_opb_register_simulink2ppc_fifo.sv - directed vector bench for opb_register_simulink2ppc_fifo
module tb_opb_register_simulink2ppc_fifo;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] HIGH = 32'h8000_00FF;

    localparam int OP_RD   = 0;
    localparam int OP_WR   = 1;
    localparam int OP_PUSH = 2;

    typedef struct {
        int          op;
        logic [3:0]  off;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus_w;
    logic        rnw;
    logic        sel;
    logic        seq_addr;
    logic [0:31] sl_dbus;
    logic        xfer_ack;
    logic        err_ack;
    logic        retry;
    logic        tout_sup;
    logic [31:0] user_data;
    logic        user_valid;
    logic        user_full;

    int n_cmp  = 0;
    int n_fail = 0;

    opb_register_simulink2ppc_fifo #(
        .C_BASEADDR (BASE),
        .C_HIGHADDR (HIGH)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus_w),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seq_addr),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (xfer_ack),
        .Sl_errAck    (err_ack),
        .Sl_retry     (retry),
        .Sl_toutSup   (tout_sup),
        .user_data_in (user_data),
        .user_valid   (user_valid),
        .user_full    (user_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_xfer(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic push_en, input logic [31:0] push_word,
                            output logic [31:0] rdata);
        logic acked;
        @(negedge clk);
        user_valid = 1'b0;
        sel    = 1'b1;
        abus   = addr;
        rnw    = rd;
        dbus_w = wdata;
        acked  = 1'b0;
        rdata  = 32'hXXXX_XXXX;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (xfer_ack) begin
                acked = 1'b1;
                rdata = sl_dbus;
                if (push_en) begin
                    user_valid = 1'b1;
                    user_data  = push_word;
                end
            end
        end
        sel    = 1'b0;
        abus   = '0;
        dbus_w = '0;
        if (!acked) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack expected ack at addr 0x%08h", addr);
        end
        @(negedge clk);
        user_valid = 1'b0;
    endtask

    task automatic rd_reg(input string name, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus_xfer(1'b1, BASE + 32'(off), 32'h0, 1'b0, 32'h0, d);
        check(name, d, exp);
    endtask

    task automatic wr_reg(input logic [3:0] off, input logic [31:0] wdata);
        logic [31:0] d;
        bus_xfer(1'b0, BASE + 32'(off), wdata, 1'b0, 32'h0, d);
    endtask

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        user_valid = 1'b1;
        user_data  = w;
    endtask

    vec_t        vt[14];
    logic [31:0] d;
    int          acks;
    logic [31:0] d_or;

    initial begin
        rst_n = 1'b0; abus = '0; be = 4'hF; dbus_w = '0; rnw = 1'b0;
        sel = 1'b0; seq_addr = 1'b0; user_data = '0; user_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ack",   {31'h0, xfer_ack},  32'h0);
        check("reset_dbus",  sl_dbus,            32'h0);
        check("reset_full",  {31'h0, user_full}, 32'h0);
        check("reset_tieoffs", {29'h0, err_ack, retry, tout_sup}, 32'h0);
        rst_n = 1'b1;

        vt[0]  = '{OP_RD,   4'h4, 32'h0,         32'h0000_0001};
        vt[1]  = '{OP_RD,   4'h0, 32'h0,         32'h0000_0000};
        vt[2]  = '{OP_RD,   4'h4, 32'h0,         32'h0000_0009};
        vt[3]  = '{OP_WR,   4'h8, 32'h0000_0008, 32'h0};
        vt[4]  = '{OP_RD,   4'h4, 32'h0,         32'h0000_0001};
        vt[5]  = '{OP_PUSH, 4'h0, 32'hDEAD_BEEF, 32'h0};
        vt[6]  = '{OP_PUSH, 4'h0, 32'h1234_5678, 32'h0};
        vt[7]  = '{OP_RD,   4'h4, 32'h0,         32'h0000_0200};
        vt[8]  = '{OP_WR,   4'h0, 32'hFFFF_FFFF, 32'h0};
        vt[9]  = '{OP_RD,   4'h8, 32'h0,         32'h0000_0000};
        vt[10] = '{OP_RD,   4'h0, 32'h0,         32'hDEAD_BEEF};
        vt[11] = '{OP_RD,   4'h0, 32'h0,         32'h1234_5678};
        vt[12] = '{OP_RD,   4'h4, 32'h0,         32'h0000_0001};
        vt[13] = '{OP_RD,   4'hC, 32'h0,         32'h0000_0000};

        for (int i = 0; i < 14; i++) begin
            case (vt[i].op)
                OP_RD:   rd_reg($sformatf("vec%0d_rd_off%0h", i, vt[i].off), vt[i].off, vt[i].exp);
                OP_WR:   wr_reg(vt[i].off, vt[i].data);
                default: push(vt[i].data);
            endcase
        end

        // Overflow: 17 pushes into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 15) check("full_before_16th", {31'h0, user_full}, 32'h0);
            if (i == 16) check("full_after_16th",  {31'h0, user_full}, 32'h1);
            user_valid = 1'b1;
            user_data  = 32'(i);
        end
        rd_reg("status_ovf", 4'h4, 32'h0000_1006);
        for (int i = 0; i < 16; i++) rd_reg($sformatf("drain_%0d", i), 4'h0, 32'(i));
        rd_reg("status_after_drain", 4'h4, 32'h0000_0005);
        wr_reg(4'h8, 32'h0000_0004);
        rd_reg("status_ovf_clr", 4'h4, 32'h0000_0001);

        // Full FIFO, push during DATA ack cycle.
        for (int i = 0; i < 16; i++) push(32'(100 + i));
        rd_reg("status_full", 4'h4, 32'h0000_1002);
        bus_xfer(1'b1, BASE, 32'h0, 1'b1, 32'hA5A5_A5A5, d);
        check("full_pop_push_data", d, 32'd100);
        rd_reg("full_pop_push_status", 4'h4, 32'h0000_1002);
        check("full_pop_push_flag", {31'h0, user_full}, 32'h1);

        // Overflow set in the same cycle as its clear.
        push(32'h77);
        rd_reg("status_ovf2", 4'h4, 32'h0000_1006);
        bus_xfer(1'b0, BASE + 32'h8, 32'h0000_0004, 1'b1, 32'h88, d);
        rd_reg("set_wins_status", 4'h4, 32'h0000_1006);
        for (int i = 0; i < 16; i++)
            rd_reg($sformatf("drain2_%0d", i), 4'h0, (i < 15) ? 32'(101 + i) : 32'hA5A5_A5A5);
        rd_reg("status_drain2", 4'h4, 32'h0000_0005);
        wr_reg(4'h8, 32'h0000_000C);
        rd_reg("status_clr_both", 4'h4, 32'h0000_0001);

        // Empty FIFO, push during DATA ack cycle.
        bus_xfer(1'b1, BASE, 32'h0, 1'b1, 32'h0000_5555, d);
        check("empty_pop_push_data", d, 32'h0);
        rd_reg("empty_pop_push_status", 4'h4, 32'h0000_0108);
        wr_reg(4'h8, 32'h0000_0008);
        rd_reg("unf_clr_status", 4'h4, 32'h0000_0100);
        rd_reg("empty_pushed_word", 4'h0, 32'h0000_5555);

        // Select held for several cycles on one DATA read.
        push(32'h11);
        push(32'h22);
        @(negedge clk);
        user_valid = 1'b0;
        sel = 1'b1; abus = BASE; rnw = 1'b1;
        acks = 0; d = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (xfer_ack) begin
                acks++;
                d = sl_dbus;
            end
        end
        sel = 1'b0; abus = '0;
        repeat (2) @(negedge clk);
        check("held_sel_acks", 32'(acks), 32'd1);
        check("held_sel_data", d, 32'h11);
        rd_reg("held_sel_status", 4'h4, 32'h0000_0100);

        // Outside the window, above and below.
        acks = 0; d_or = '0;
        @(negedge clk);
        sel = 1'b1; rnw = 1'b1; abus = HIGH + 32'h1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (xfer_ack) acks++;
            d_or = d_or | sl_dbus;
        end
        abus = BASE - 32'h4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (xfer_ack) acks++;
            d_or = d_or | sl_dbus;
        end
        sel = 1'b0; abus = '0;
        check("miss_acks", 32'(acks), 32'd0);
        check("miss_dbus", d_or, 32'h0);
        rd_reg("miss_no_pop", 4'h0, 32'h22);

        // Reset asserted during the ack cycle.
        push(32'h33);
        @(negedge clk);
        user_valid = 1'b0;
        sel = 1'b1; abus = BASE + 32'h4; rnw = 1'b1;
        @(negedge clk);
        check("pre_reset_ack", {31'h0, xfer_ack}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_ack",  {31'h0, xfer_ack}, 32'h0);
        check("mid_reset_dbus", sl_dbus, 32'h0);
        sel = 1'b0; abus = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg("post_reset_status", 4'h4, 32'h0000_0001);

`ifdef OPB_S2P_PEEK_EN
        push(32'h00C0_FFEE);
        rd_reg("peek_1", 4'hC, 32'h00C0_FFEE);
        rd_reg("peek_2", 4'hC, 32'h00C0_FFEE);
        rd_reg("peek_status", 4'h4, 32'h0000_0100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
